// File: rtl/shift_pkg.sv
// Shared definitions for the shift sweep sequencer.
//   state_t   : sequencer FSM states
//   N_DEFAULT : default log2 of the operand width
//   W         : operand width for the default configuration (2**N_DEFAULT)
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEFAULT = 3;
  localparam int W         = 2 ** N_DEFAULT;

endpackage

// File: rtl/shift_sweep_sequencer_tick_gen.sv
// Free-running prescaler that produces a one-cycle tick every TICK_DIV
// enabled cycles.
//   clk   : system clock
//   reset : synchronous active-high reset, clears the count
//   clr   : synchronous clear of the count (takes effect over en)
//   en    : count enable
//   tick  : high while enabled and the count sits at TICK_DIV-1
module tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the step happens on the same edge the count wraps.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/shift_sweep_sequencer.sv
// Control stage in front of the multi-mode barrel shifter. Holds the operand,
// direction and shift amount, steps the amount manually or on a prescaled
// tick, registers the shifter result, and reports completion of a full sweep.
//   clk, reset       : clock and synchronous active-high reset
//   load, din, dir_in: capture a new operand and direction
//   start, stop, step: sweep control pulses
//   a_out, amt_out, s_out : shifter A, AMT and s
//   y_in             : shifter result Y for the current outputs
//   y_reg            : registered result (lags amt_out by one step)
//   busy             : high while sweeping automatically
//   done             : one-cycle pulse when an automatic sweep wraps
module shift_sweep_sequencer
  import shift_pkg::*;
#(
  parameter int          N        = 3,
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [2**N-1:0]   din,
  input  logic              dir_in,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  output logic [2**N-1:0]   a_out,
  output logic [N-1:0]      amt_out,
  output logic              s_out,
  input  logic [2**N-1:0]   y_in,
  output logic [2**N-1:0]   y_reg,
  output logic              busy,
  output logic              done
);

  localparam logic [N-1:0] AMT_MAX = '1;

  state_t state;
  logic   tick;

  // The prescaler only runs in RUN; a stop clears it so a resumed sweep
  // always waits a full period before its first step.
  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   ((state != RUN) || stop),
    .en    (state == RUN),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_out   <= '0;
      amt_out <= '0;
      s_out   <= 1'b0;
      y_reg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            state   <= ARMED;
            a_out   <= din;
            s_out   <= dir_in;
            amt_out <= '0;
            y_reg   <= '0;
          end
        end

        ARMED, DONE: begin
          if (load) begin
            state   <= ARMED;
            a_out   <= din;
            s_out   <= dir_in;
            amt_out <= '0;
            y_reg   <= '0;
          end else if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end else if (step) begin
            // Manual steps wrap silently; done belongs to automatic sweeps.
            state   <= ARMED;
            y_reg   <= y_in;
            amt_out <= amt_out + 1'b1;
          end
        end

        RUN: begin
          if (stop) begin
            state <= ARMED;
            busy  <= 1'b0;
          end else if (tick) begin
            y_reg   <= y_in;
            amt_out <= amt_out + 1'b1;
            if (amt_out == AMT_MAX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sweep_sequencer.sv
// Directed self-checking bench for shift_sweep_sequencer (N=3, TICK_DIV=4).
// The shifter is replaced by a stub: y_in = a_out ^ amt_out (zero-extended).
module tb_shift_sweep_sequencer;
  import shift_pkg::*;

  localparam int N  = 3;
  localparam int DW = 2 ** N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dir_in = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          step = 1'b0;
  logic [DW-1:0] a_out;
  logic [N-1:0]  amt_out;
  logic          s_out;
  logic [DW-1:0] y_in;
  logic [DW-1:0] y_reg;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  assign y_in = a_out ^ {{(DW-N){1'b0}}, amt_out};

  shift_sweep_sequencer #(
    .N        (N),
    .TICK_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (din),
    .dir_in  (dir_in),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .a_out   (a_out),
    .amt_out (amt_out),
    .s_out   (s_out),
    .y_in    (y_in),
    .y_reg   (y_reg),
    .busy    (busy),
    .done    (done)
  );

  // Advance one clock and settle; done pulses are counted as they are seen.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with every input asserted.
    reset = 1'b1; load = 1'b1; start = 1'b1; stop = 1'b1; step = 1'b1;
    din = 8'hFF; dir_in = 1'b1;
    cyc();
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_a",     32'(a_out),   32'h0);
    check("rst_amt",   32'(amt_out), 32'h0);
    check("rst_s",     32'(s_out),   32'h0);
    check("rst_y",     32'(y_reg),   32'h0);
    check("rst_busy",  32'(busy),    32'h0);
    check("rst_done",  32'(done),    32'h0);
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    cyc();
    step = 1'b0;
    check("idle_step_amt",   32'(amt_out),   32'h0);
    check("idle_step_state", 32'(dut.state), 32'(IDLE));

    // 2. Manual stepping after a load.
    din = 8'h96; dir_in = 1'b1; load = 1'b1;
    cyc();
    load = 1'b0;
    check("load_state", 32'(dut.state), 32'(ARMED));
    check("load_a",     32'(a_out),     32'h96);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
    end
    check("man_amt", 32'(amt_out), 32'h3);
    check("man_y",   32'(y_reg),   32'h94);
    check("man_s",   32'(s_out),   32'h1);

    // 3. Full automatic sweep on 8'hA5.
    din = 8'hA5; dir_in = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0;
    check("sweep_load_amt", 32'(amt_out), 32'h0);
    check("sweep_load_y",   32'(y_reg),   32'h0);
    done_seen = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("sweep_busy",  32'(busy),      32'h1);
    check("sweep_state", 32'(dut.state), 32'(RUN));
    for (int k = 1; k <= 8; k++) begin
      repeat (3) cyc();
      check($sformatf("sweep_hold_%0d", k), 32'(amt_out), 32'(k - 1));
      cyc();
      check($sformatf("sweep_step_%0d", k), 32'(amt_out), 32'(k % 8));
    end
    check("sweep_done_pulse", 32'(done),      32'h1);
    check("sweep_done_state", 32'(dut.state), 32'(DONE));
    check("sweep_done_busy",  32'(busy),      32'h0);
    check("sweep_done_y",     32'(y_reg),     32'hA2);
    cyc();
    check("sweep_done_low",   32'(done),      32'h0);
    check("sweep_done_count", 32'(done_seen), 32'h1);
    check("sweep_done_hold",  32'(dut.state), 32'(DONE));

    // 4. Restart from DONE, then stop on the exact tick cycle.
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("restart_state", 32'(dut.state), 32'(RUN));
    repeat (8) cyc();
    check("restart_amt", 32'(amt_out), 32'h2);
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_amt",   32'(amt_out),   32'h2);
    check("stop_state", 32'(dut.state), 32'(ARMED));
    check("stop_busy",  32'(busy),      32'h0);
    check("stop_y",     32'(y_reg),     32'hA4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    check("resume_hold", 32'(amt_out), 32'h2);
    cyc();
    check("resume_amt", 32'(amt_out), 32'h3);
    check("resume_y",   32'(y_reg),   32'hA7);

    // 5. Load and step together in ARMED: the reload wins.
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop2_state", 32'(dut.state), 32'(ARMED));
    din = 8'h3C; dir_in = 1'b0; load = 1'b1; step = 1'b1;
    cyc();
    load = 1'b0; step = 1'b0;
    check("reload_a",     32'(a_out),     32'h3C);
    check("reload_amt",   32'(amt_out),   32'h0);
    check("reload_y",     32'(y_reg),     32'h0);
    check("reload_s",     32'(s_out),     32'h0);
    check("reload_state", 32'(dut.state), 32'(ARMED));

    // 6. Reset in the middle of a sweep at amount 5.
    done_seen = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (20) cyc();
    check("mid_amt", 32'(amt_out), 32'h5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    check("mid_rst_a",     32'(a_out),     32'h0);
    check("mid_rst_amt",   32'(amt_out),   32'h0);
    check("mid_rst_y",     32'(y_reg),     32'h0);
    check("mid_rst_busy",  32'(busy),      32'h0);
    check("mid_rst_done",  32'(done_seen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sweep_sequencer.md
Name: shift_sweep_sequencer

Overview:
- Upstream control stage for the multi-mode barrel shifter.
- Holds the operand, direction select and shift amount that drive the shifter's A, AMT and s inputs.
- Steps the shift amount manually or automatically and registers the shifter's result for display logic.
- Drives a complete 0 to 2**N-1 sweep, then reports done.

Parameters:
N, 3, log2 of data width; data is 2**N bits, amount is N bits
TICK_DIV, 100_000_000, clk cycles between automatic steps in RUN (must be >= 2)

Ports:
clk  input  1  system clock; all logic rising-edge
reset  input  1  synchronous, active-high reset
load  input  1  single-cycle pulse; capture din and dir_in
din  input  2**N  operand to shift
dir_in  input  1  direction select, latched on load (0 = right shifter path, 1 = left)
start  input  1  single-cycle pulse; begin automatic sweep
stop  input  1  single-cycle pulse; abort automatic sweep
step  input  1  single-cycle pulse; manual single step
a_out  output  2**N  operand to shifter A
amt_out  output  N  shift amount to shifter AMT
s_out  output  1  direction to shifter s
y_in  input  2**N  shifter result Y (combinational from a_out/amt_out/s_out)
y_reg  output  2**N  registered result
busy  output  1  high in RUN
done  output  1  one-cycle pulse on sweep completion

Behaviour:
- Reset is synchronous and active-high, and wins over everything. On reset:
  - state = IDLE
  - a_out, amt_out, s_out, y_reg = 0
  - busy, done = 0
  - tick counter = 0
- States: IDLE, ARMED, RUN, DONE. Input priority each cycle: load > stop > start > step.
- IDLE:
  - load -> ARMED; a_out <= din, s_out <= dir_in, amt_out <= 0, y_reg <= 0.
  - start, stop and step are ignored.
- ARMED:
  - load reloads exactly as in IDLE and stays in ARMED.
  - step: y_reg <= y_in (the value for the current amt_out), then amt_out <= amt_out + 1 mod 2**N, all in the same edge. y_reg therefore always lags the displayed amount by one.
  - start -> RUN; tick counter cleared to 0.
  - stop is ignored.
- RUN:
  - busy = 1. The tick counter increments every cycle.
  - When the counter reaches TICK_DIV-1, perform a step (same rule as ARMED) and clear the counter.
  - If that step wraps amt_out from 2**N-1 to 0: go to DONE and assert done for exactly that one cycle (registered, coincident with DONE entry).
  - stop -> ARMED with no step on that cycle. amt_out and y_reg hold; the tick counter clears.
  - load, start and step are ignored in RUN.
- DONE:
  - Outputs hold; amt_out = 0; y_reg = result for amount 2**N-1.
  - load -> ARMED (reload).
  - start -> RUN (new sweep on the same operand).
  - step behaves as in ARMED and moves to ARMED.
- Manual stepping past 2**N-1 in ARMED wraps to 0 silently, with no done.
- s_out and a_out change only on load. This keeps shifter inputs stable between steps.
- Latency:
  - amt_out updates 1 cycle after the step or tick edge.
  - y_reg reflects the pre-increment amount on that same edge.
- Simultaneous events:
  - load with step in ARMED: the reload wins and no step occurs.
  - stop with a tick in RUN: stop wins.

Decomposition:
- Shared package shift_pkg:
  - state enum typedef (IDLE, ARMED, RUN, DONE)
  - localparam W = 2**N
- One sub-module: tick_gen (parameter TICK_DIV; ports clk, reset, clr, en, tick). This is the free-running prescaler producing a one-cycle tick.
- The FSM and datapath registers stay in the top module.
- Top-level integration instantiates shift_sweep_sequencer next to multi-mode barrel shifter, wiring a_out/amt_out/s_out to A/AMT/s and Y back to y_in.

Test Plan:
1. Reset with all inputs asserted -> next cycle: state IDLE, all outputs 0, done 0. A step in IDLE leaves amt_out = 0.
2. Load din=8'h96, dir_in=1; bench stub y_in = a_out ^ {5'b0, amt_out}; issue 3 step pulses -> amt_out = 3, y_reg = 8'h94 (from amt 2), s_out = 1.
3. TICK_DIV=4, load 8'hA5, start:
   - busy rises the next cycle.
   - amt_out advances every 4 cycles.
   - After 8 ticks, amt_out = 0, done pulses exactly once, state DONE, busy = 0.
4. In RUN with TICK_DIV=4, assert stop on the same cycle as a tick -> amt_out unchanged, state ARMED. A following start resumes from the held amount.
5. In ARMED, assert load (din=8'h3C) and step together -> a_out = 8'h3C, amt_out = 0, y_reg = 0, no step.
6. Reset asserted mid-RUN at amt_out = 5 -> next cycle all outputs 0, IDLE, no done pulse.
